bs_turn_controller: RTL and testbench



---
 rtl/bs_turn_controller.sv | 181 ++++++++++++++++++
 tb/tb_bs_turn_controller.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bs_turn_controller.sv
// Two-player Battleship sequencer: latches both ship placements, alternates shots, tracks lives and declares a winner.
// Optional macro BS_HIT_AGAIN_EN: a hit that does not end the game gives the shooter another turn.
module bs_turn_controller #(
    parameter int BOARD_W     = 16,
    parameter int MAX_SHIPS   = 6,
    parameter int SHOW_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [BOARD_W-1:0] sw,
    input  logic               btn_load,
    input  logic               btn_fire,
    output logic [BOARD_W-1:0] board_a,
    output logic [BOARD_W-1:0] board_b,
    output logic [BOARD_W-1:0] shots_a,
    output logic [BOARD_W-1:0] shots_b,
    output logic [4:0]         lives_a,
    output logic [4:0]         lives_b,
    output logic               turn,
    output logic [2:0]         state,
    output logic               hit_flag,
    output logic               miss_flag,
    output logic               err,
    output logic               game_over,
    output logic               winner
);

    localparam logic [2:0] S_PLACE_A  = 3'd0;
    localparam logic [2:0] S_PLACE_B  = 3'd1;
    localparam logic [2:0] S_TURN_A   = 3'd2;
    localparam logic [2:0] S_RESULT_A = 3'd3;
    localparam logic [2:0] S_TURN_B   = 3'd4;
    localparam logic [2:0] S_RESULT_B = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    // The counter only has to hold SHOW_CYCLES-1, which always fits in clog2(SHOW_CYCLES) bits.
    localparam int               CNT_W     = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [4:0]       MAX_LIVES = 5'(MAX_SHIPS);

    function automatic logic [4:0] popcount(input logic [BOARD_W-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < BOARD_W; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    logic             load_prev;
    logic             fire_prev;
    logic [CNT_W-1:0] cnt;
    logic             load_press;
    logic             fire_press;
    logic [4:0]       sw_count;
    logic             place_ok;
    logic             shot_ok;
    logic             shot_hit;
    logic [4:0]       opp_lives;

    assign load_press = btn_load & ~load_prev;
    assign fire_press = btn_fire & ~fire_prev;
    assign sw_count   = popcount(sw);
    assign place_ok   = (sw != '0) && (sw_count <= MAX_LIVES);

    // Shot legality and outcome are judged from the active shooter's point of view.
    always_comb begin
        shot_ok  = 1'b0;
        shot_hit = 1'b0;
        if (state == S_TURN_A) begin
            shot_ok  = $onehot(sw) && ((sw & shots_a) == '0);
            shot_hit = (sw & board_b) != '0;
        end else if (state == S_TURN_B) begin
            shot_ok  = $onehot(sw) && ((sw & shots_b) == '0);
            shot_hit = (sw & board_a) != '0;
        end
    end

    assign opp_lives = (state == S_RESULT_A) ? lives_b : lives_a;

    always_ff @(posedge clk) begin
        if (clr) begin
            board_a   <= '0;
            board_b   <= '0;
            shots_a   <= '0;
            shots_b   <= '0;
            lives_a   <= '0;
            lives_b   <= '0;
            turn      <= 1'b0;
            state     <= S_PLACE_A;
            hit_flag  <= 1'b0;
            miss_flag <= 1'b0;
            err       <= 1'b0;
            game_over <= 1'b0;
            winner    <= 1'b0;
            cnt       <= '0;
            load_prev <= 1'b1;
            fire_prev <= 1'b1;
        end else begin
            load_prev <= btn_load;
            fire_prev <= btn_fire;
            err       <= 1'b0;
            case (state)
                S_PLACE_A: begin
                    if (load_press) begin
                        if (place_ok) begin
                            board_a <= sw;
                            lives_a <= sw_count;
                            state   <= S_PLACE_B;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_PLACE_B: begin
                    if (load_press) begin
                        if (place_ok) begin
                            board_b <= sw;
                            lives_b <= sw_count;
                            turn    <= 1'b0;
                            state   <= S_TURN_A;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_TURN_A, S_TURN_B: begin
                    if (fire_press) begin
                        if (shot_ok) begin
                            if (state == S_TURN_A) begin
                                shots_a <= shots_a | sw;
                                if (shot_hit) lives_b <= lives_b - 5'd1;
                                state <= S_RESULT_A;
                            end else begin
                                shots_b <= shots_b | sw;
                                if (shot_hit) lives_a <= lives_a - 5'd1;
                                state <= S_RESULT_B;
                            end
                            hit_flag  <= shot_hit;
                            miss_flag <= ~shot_hit;
                            cnt       <= CNT_LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_RESULT_A, S_RESULT_B: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        hit_flag  <= 1'b0;
                        miss_flag <= 1'b0;
                        if (opp_lives == 5'd0) begin
                            state     <= S_DONE;
                            game_over <= 1'b1;
                            winner    <= (state == S_RESULT_B);
                        end else begin
`ifdef BS_HIT_AGAIN_EN
                            if (hit_flag) begin
                                state <= (state == S_RESULT_A) ? S_TURN_A : S_TURN_B;
                            end else begin
                                state <= (state == S_RESULT_A) ? S_TURN_B : S_TURN_A;
                                turn  <= ~turn;
                            end
`else
                            state <= (state == S_RESULT_A) ? S_TURN_B : S_TURN_A;
                            turn  <= ~turn;
`endif
                        end
                    end
                end
                S_DONE: begin
                end
                default: begin
                    state <= S_PLACE_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bs_turn_controller.sv
// Scoreboard bench for bs_turn_controller: stimulus queues expected output snapshots, a monitor
// compares them against every observed change of the DUT outputs.
module tb_bs_turn_controller;

    typedef struct packed {
        logic [2:0]  state;
        logic        turn;
        logic        err;
        logic        hit;
        logic        miss;
        logic        game_over;
        logic        winner;
        logic [4:0]  lives_a;
        logic [4:0]  lives_b;
        logic [15:0] board_a;
        logic [15:0] board_b;
        logic [15:0] shots_a;
        logic [15:0] shots_b;
    } snap_t;

    typedef struct {
        snap_t s;
        int    dwell;
        bit    dchk;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] sw;
    logic        btn_load;
    logic        btn_fire;
    logic [15:0] board_a, board_b, shots_a, shots_b;
    logic [4:0]  lives_a, lives_b;
    logic        turn, hit_flag, miss_flag, err, game_over, winner;
    logic [2:0]  state;

    exp_t  sb_q[$];
    snap_t expected;
    int    checks   = 0;
    int    failures = 0;
    bit    mon_en   = 1'b0;
    bit    fire_hold = 1'b0;

    bs_turn_controller #(.BOARD_W(16), .MAX_SHIPS(6), .SHOW_CYCLES(4)) dut (
        .clk(clk), .clr(clr), .sw(sw), .btn_load(btn_load), .btn_fire(btn_fire),
        .board_a(board_a), .board_b(board_b), .shots_a(shots_a), .shots_b(shots_b),
        .lives_a(lives_a), .lives_b(lives_b), .turn(turn), .state(state),
        .hit_flag(hit_flag), .miss_flag(miss_flag), .err(err),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic pushExpect(input int dwell, input bit dchk);
        exp_t e;
        e.s     = expected;
        e.dwell = dwell;
        e.dchk  = dchk;
        sb_q.push_back(e);
    endtask

    task automatic expectReset();
        expected = '0;
        pushExpect(0, 1'b0);
    endtask

    task automatic expectErr();
        expected.err = 1'b1;
        pushExpect(0, 1'b0);
        expected.err = 1'b0;
        pushExpect(1, 1'b1);
    endtask

    task automatic applyStimulus(input logic ld, input logic fr, input logic [15:0] v, input int idle);
        sw       = v;
        btn_load = ld;
        btn_fire = fr | fire_hold;
        @(posedge clk); #2;
        btn_load = 1'b0;
        btn_fire = fire_hold;
        repeat (idle) @(posedge clk);
        if (idle > 0) #2;
    endtask

    task automatic doReset(input int n);
        clr = 1'b1;
        repeat (n) @(posedge clk);
        #2 clr = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic checkOutput(input snap_t cur, input int dwell);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_output t=%0t got=%h expected=<none>", $time, cur);
        end else begin
            e = sb_q.pop_front();
            if (cur !== e.s || (e.dchk && dwell != e.dwell)) begin
                failures++;
                $display("[TB] FAIL snapshot t=%0t got=%h dwell=%0d expected=%h dwell=%0d(chk=%0d)",
                         $time, cur, dwell, e.s, e.dwell, e.dchk);
            end
        end
    endtask

    // Monitor: every change of the output snapshot is one DUT response to be scored.
    initial begin
        snap_t cur, last;
        bit    first = 1'b1;
        int    since = 0;
        last = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = {state, turn, err, hit_flag, miss_flag, game_over, winner,
                       lives_a, lives_b, board_a, board_b, shots_a, shots_b};
                if (first || cur !== last) begin
                    checkOutput(cur, since + 1);
                    first = 1'b0;
                    last  = cur;
                    since = 0;
                end else begin
                    since++;
                end
            end
        end
    end

    initial begin
        clr      = 1'b1;
        btn_load = 1'b1;
        btn_fire = 1'b0;
        sw       = 16'h0007;
        repeat (3) @(posedge clk);
        #2;
        expectReset();
        mon_en = 1'b1;
        @(posedge clk); #2 clr = 1'b0;
        // btn_load held through reset must not load
        repeat (3) @(posedge clk);
        #2 btn_load = 1'b0;
        @(posedge clk); #2;

        expectErr();
        applyStimulus(1, 0, 16'h0000, 3);
        expectErr();
        applyStimulus(1, 0, 16'h00FF, 3);
        expectErr();
        applyStimulus(1, 0, 16'h007F, 3);
        applyStimulus(0, 1, 16'h0001, 3);

        expected.state = 3'd1; expected.board_a = 16'h0007; expected.lives_a = 5'd3;
        pushExpect(0, 0);
        applyStimulus(1, 0, 16'h0007, 3);
        applyStimulus(0, 1, 16'h0001, 3);

        expected.state = 3'd2; expected.board_b = 16'h8001; expected.lives_b = 5'd2;
        pushExpect(0, 0);
        applyStimulus(1, 0, 16'h8001, 3);

        // A hits 0x0001; a second fire during RESULT_A must be ignored
        expected.state = 3'd3; expected.hit = 1; expected.lives_b = 5'd1; expected.shots_a = 16'h0001;
        pushExpect(0, 0);
`ifdef BS_HIT_AGAIN_EN
        expected.state = 3'd2; expected.hit = 0;
        pushExpect(4, 1);
`else
        expected.state = 3'd4; expected.turn = 1; expected.hit = 0;
        pushExpect(4, 1);
`endif
        applyStimulus(0, 1, 16'h0001, 1);
        applyStimulus(0, 1, 16'h0002, 8);
`ifdef BS_HIT_AGAIN_EN
        expected.state = 3'd3; expected.miss = 1; expected.shots_a = 16'h0011;
        pushExpect(0, 0);
        expected.state = 3'd4; expected.turn = 1; expected.miss = 0;
        pushExpect(4, 1);
        applyStimulus(0, 1, 16'h0010, 8);
`endif

        expected.state = 3'd5; expected.miss = 1; expected.shots_b = 16'h0100;
        pushExpect(0, 0);
        expected.state = 3'd2; expected.turn = 0; expected.miss = 0;
        pushExpect(4, 1);
        applyStimulus(0, 1, 16'h0100, 8);

        expected.state = 3'd3; expected.miss = 1; expected.shots_a = expected.shots_a | 16'h0002;
        pushExpect(0, 0);
        expected.state = 3'd4; expected.turn = 1; expected.miss = 0;
        pushExpect(4, 1);
        applyStimulus(0, 1, 16'h0002, 8);

        expectErr();
        applyStimulus(0, 1, 16'h0100, 3);

        expected.state = 3'd5; expected.miss = 1; expected.shots_b = 16'h0300;
        pushExpect(0, 0);
        expected.state = 3'd2; expected.turn = 0; expected.miss = 0;
        pushExpect(4, 1);
        applyStimulus(0, 1, 16'h0200, 8);

        expectErr();
        applyStimulus(0, 1, 16'h0003, 3);
        expectErr();
        applyStimulus(0, 1, 16'h0000, 3);

        expected.state = 3'd3; expected.hit = 1; expected.lives_b = 5'd0;
        expected.shots_a = expected.shots_a | 16'h8000;
        pushExpect(0, 0);
        expected.state = 3'd6; expected.hit = 0; expected.game_over = 1; expected.winner = 0;
        pushExpect(4, 1);
        applyStimulus(0, 1, 16'h8000, 8);

        applyStimulus(1, 0, 16'h0007, 2);
        applyStimulus(0, 1, 16'h0004, 2);
        applyStimulus(1, 1, 16'h0008, 2);

        // Second game: btn_fire held across clr and both loads
        fire_hold = 1'b1;
        btn_fire  = 1'b1;
        expectReset();
        doReset(2);
        expected.state = 3'd1; expected.board_a = 16'h0030; expected.lives_a = 5'd2;
        pushExpect(0, 0);
        applyStimulus(1, 0, 16'h0030, 3);
        expected.state = 3'd2; expected.board_b = 16'h0C00; expected.lives_b = 5'd2;
        pushExpect(0, 0);
        applyStimulus(1, 0, 16'h0C00, 4);
        sw = 16'h0001;
        repeat (4) @(posedge clk);
        #2;
        fire_hold = 1'b0;
        btn_fire  = 1'b0;
        @(posedge clk); #2;

        expected.state = 3'd3; expected.miss = 1; expected.shots_a = 16'h0001;
        pushExpect(0, 0);
        expected.state = 3'd4; expected.turn = 1; expected.miss = 0;
        pushExpect(4, 1);
        applyStimulus(0, 1, 16'h0001, 8);

        expected.state = 3'd5; expected.hit = 1; expected.lives_a = 5'd1; expected.shots_b = 16'h0010;
        pushExpect(0, 0);
`ifdef BS_HIT_AGAIN_EN
        expected.state = 3'd4; expected.hit = 0;
        pushExpect(4, 1);
        applyStimulus(0, 1, 16'h0010, 8);
`else
        expected.state = 3'd2; expected.turn = 0; expected.hit = 0;
        pushExpect(4, 1);
        applyStimulus(0, 1, 16'h0010, 8);
        expected.state = 3'd3; expected.miss = 1; expected.shots_a = 16'h0003;
        pushExpect(0, 0);
        expected.state = 3'd4; expected.turn = 1; expected.miss = 0;
        pushExpect(4, 1);
        applyStimulus(0, 1, 16'h0002, 8);
`endif

        // Load and fire pressed together: only the fire acts in TURN_B
        expected.state = 3'd5; expected.hit = 1; expected.lives_a = 5'd0; expected.shots_b = 16'h0030;
        pushExpect(0, 0);
        expected.state = 3'd6; expected.hit = 0; expected.game_over = 1; expected.winner = 1;
        pushExpect(4, 1);
        applyStimulus(1, 1, 16'h0020, 8);

        // Third game: MAX_SHIPS boundary, then clr in the middle of RESULT_A
        expectReset();
        doReset(2);
        expected.state = 3'd1; expected.board_a = 16'h003F; expected.lives_a = 5'd6;
        pushExpect(0, 0);
        applyStimulus(1, 0, 16'h003F, 3);
        expected.state = 3'd2; expected.board_b = 16'h0001; expected.lives_b = 5'd1;
        pushExpect(0, 0);
        applyStimulus(1, 0, 16'h0001, 3);
        expected.state = 3'd3; expected.hit = 1; expected.lives_b = 5'd0; expected.shots_a = 16'h0001;
        pushExpect(0, 0);
        applyStimulus(0, 1, 16'h0001, 0);
        expectReset();
        doReset(2);
        expected.state = 3'd1; expected.board_a = 16'h0003; expected.lives_a = 5'd2;
        pushExpect(0, 0);
        applyStimulus(1, 0, 16'h0003, 10);

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL missing_output got=%0d pending expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
